// File: rtl/mul_operand_loader_pkg.sv
// rtl/mul_operand_loader_pkg.sv - shared widths and FSM state encodings for the operand loader
package mul_io_defs;

  localparam int OP_W   = 1024;
  localparam int WORD_W = 32;
  localparam int WORDS  = OP_W / WORD_W;
  localparam int CNT_W  = 16;
  localparam int NCNT_W = 6;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_operand_loader_word_packer.sv
// rtl/mul_operand_loader_word_packer.sv - packs words LSW-first into one operand register with a fill count
module word_packer
  import mul_io_defs::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr,
  input  logic [WORD_W-1:0] word,
  input  logic              clr,
  output logic [OP_W-1:0]   data,
  output logic [NCNT_W-1:0] cnt,
  output logic              full
);

  logic [OP_W-1:0]   r_data;
  logic [NCNT_W-1:0] r_cnt;
  logic              w_full;

  assign w_full = (r_cnt == NCNT_W'(WORDS));

  // Append the word at the current count; clear wins, a full operand drops the word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (wr && !w_full) begin
      r_data[int'(r_cnt)*WORD_W +: WORD_W] <= word;
      r_cnt                                 <= r_cnt + NCNT_W'(1);
    end
  end

  assign data = r_data;
  assign cnt  = r_cnt;
  assign full = w_full;

endmodule

// File: rtl/mul_operand_loader.sv
// rtl/mul_operand_loader.sv - loads two operands from the touchscreen path and sequences the multiplier
module mul_operand_loader
  import mul_io_defs::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_sel,
  input  logic              clr,
  input  logic              go,
  input  logic              mul_done,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic [NCNT_W-1:0] a_cnt,
  output logic [NCNT_W-1:0] b_cnt,
  output logic              in_ready,
  output logic              start,
  output logic              busy,
  output logic              res_valid,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              err
);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_run;
  logic              r_res_valid;
  logic              r_err;
  logic              w_in_ready;
  logic              w_wr_a;
  logic              w_wr_b;
  logic              w_full_a;
  logic              w_full_b;
  logic              w_wrote;
  logic              w_word_rej;
  logic              w_go_ok;
  logic              w_go_rej;

  // Ready is forced low while reset is held so every output reads 0 during reset
  assign w_in_ready = resetn && ((r_state == ST_LOAD) || (r_state == ST_DONE));
  assign w_wr_a     = w_in_ready && in_valid && !in_sel;
  assign w_wr_b     = w_in_ready && in_valid &&  in_sel;
  assign w_wrote    = (w_wr_a && !w_full_a) || (w_wr_b && !w_full_b);
  assign w_word_rej = (w_wr_a && w_full_a) || (w_wr_b && w_full_b);
  // a_cnt/b_cnt are registered, so go sees the counts from before this cycle's write
  assign w_go_ok    = (a_cnt != '0) && (b_cnt != '0);
  assign w_go_rej   = (r_state == ST_LOAD) && go && !w_go_ok;

  word_packer u_pack_a (
    .clk    (clk),
    .resetn (resetn),
    .wr     (w_wr_a),
    .word   (in_word),
    .clr    (clr),
    .data   (op_a),
    .cnt    (a_cnt),
    .full   (w_full_a)
  );

  word_packer u_pack_b (
    .clk    (clk),
    .resetn (resetn),
    .wr     (w_wr_b),
    .word   (in_word),
    .clr    (clr),
    .data   (op_b),
    .cnt    (b_cnt),
    .full   (w_full_b)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_LOAD;
    else         r_state <= w_next;
  end

  // Next-state logic; clr returns to LOAD from any state
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  if (go && w_go_ok) w_next = ST_START;
        ST_START: w_next = ST_RUN;
        ST_RUN:   if (mul_done) w_next = ST_DONE;
        ST_DONE:  if (go) w_next = ST_START;
        default:  w_next = ST_LOAD;
      endcase
    end
  end

  // Run-cycle counter: zeroed entering START, saturating count of RUN cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run <= '0;
    end else if (clr || (w_next == ST_START)) begin
      r_run <= '0;
    end else if ((r_state == ST_RUN) && (r_run != '1)) begin
      r_run <= r_run + CNT_W'(1);
    end
  end

  // Product-valid flag: set on completion, dropped when operands change or a new run begins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_res_valid <= 1'b0;
    end else if (clr) begin
      r_res_valid <= 1'b0;
    end else if ((r_state == ST_RUN) && mul_done) begin
      r_res_valid <= 1'b1;
    end else if ((r_state == ST_DONE) && (go || w_wrote)) begin
      r_res_valid <= 1'b0;
    end
  end

  // Error pulse for a word into a full operand or a go with an empty operand
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_err <= 1'b0;
    else         r_err <= !clr && (w_word_rej || w_go_rej);
  end

  assign in_ready   = w_in_ready;
  assign start      = (r_state == ST_START);
  assign busy       = (r_state == ST_RUN);
  assign res_valid  = r_res_valid;
  assign run_cycles = r_run;
  assign err        = r_err;

endmodule

// File: tb/tb_mul_operand_loader.sv
// tb/tb_mul_operand_loader.sv - scoreboard bench for mul_operand_loader against a queue-based model
module tb_mul_operand_loader;

  localparam int M_LOAD  = 0;
  localparam int M_START = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic [31:0]   in_word;
  logic          in_sel;
  logic          clr;
  logic          go;
  logic          mul_done;
  logic [1023:0] op_a;
  logic [1023:0] op_b;
  logic [5:0]    a_cnt;
  logic [5:0]    b_cnt;
  logic          in_ready;
  logic          start;
  logic          busy;
  logic          res_valid;
  logic [15:0]   run_cycles;
  logic          err;

  mul_operand_loader dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_sel     (in_sel),
    .clr        (clr),
    .go         (go),
    .mul_done   (mul_done),
    .op_a       (op_a),
    .op_b       (op_b),
    .a_cnt      (a_cnt),
    .b_cnt      (b_cnt),
    .in_ready   (in_ready),
    .start      (start),
    .busy       (busy),
    .res_valid  (res_valid),
    .run_cycles (run_cycles),
    .err        (err)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [1023:0] op_a;
    logic [1023:0] op_b;
    logic [5:0]    a_cnt;
    logic [5:0]    b_cnt;
    logic          in_ready;
    logic          start;
    logic          busy;
    logic          res_valid;
    logic [15:0]   run_cycles;
    logic          err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          m_mode;
  bit          m_resv;
  bit          m_err;
  int          m_run;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_op(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int k;
    k = 0;
    n_tests++;
    if (act !== exp) begin
      for (int i = 31; i >= 0; i--)
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
      n_fail++;
      $display("FAIL %s: word %0d got %08h expected %08h at %0t", nm, k, act[k*32 +: 32], exp[k*32 +: 32], $time);
    end
  endtask

  function automatic logic [1023:0] pack_op(input bit sel);
    logic [1023:0] v;
    v = '0;
    if (!sel) foreach (qa[i]) v[i*32 +: 32] = qa[i];
    else      foreach (qb[i]) v[i*32 +: 32] = qb[i];
    return v;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_mode = M_LOAD;
    m_resv = 0;
    m_err  = 0;
    m_run  = 0;
  endtask

  // One clock of stimulus: drive at negedge, advance the model, queue what the DUT must show after the edge
  task automatic step(input bit iv, input logic [31:0] w, input bit sel, input bit c, input bit g, input bit md);
    int   na;
    int   nb;
    exp_t e;
    @(negedge clk);
    in_valid = iv; in_word = w; in_sel = sel; clr = c; go = g; mul_done = md;
    na = qa.size();
    nb = qb.size();
    m_err = 0;
    if (c) begin
      model_reset();
    end else begin
      if ((m_mode == M_LOAD || m_mode == M_DONE) && iv) begin
        if ((sel ? qb.size() : qa.size()) == 32) m_err = 1;
        else begin
          if (sel) qb.push_back(w); else qa.push_back(w);
          if (m_mode == M_DONE) m_resv = 0;
        end
      end
      case (m_mode)
        M_LOAD:  if (g) begin
                   if (na > 0 && nb > 0) begin m_mode = M_START; m_run = 0; end
                   else m_err = 1;
                 end
        M_START: m_mode = M_RUN;
        M_RUN:   begin
                   if (m_run < 65535) m_run++;
                   if (md) begin m_mode = M_DONE; m_resv = 1; end
                 end
        default: if (g) begin m_mode = M_START; m_run = 0; m_resv = 0; end
      endcase
    end
    e.op_a       = pack_op(0);
    e.op_b       = pack_op(1);
    e.a_cnt      = 6'(qa.size());
    e.b_cnt      = 6'(qb.size());
    e.in_ready   = (m_mode == M_LOAD) || (m_mode == M_DONE);
    e.start      = (m_mode == M_START);
    e.busy       = (m_mode == M_RUN);
    e.res_valid  = m_resv;
    e.run_cycles = 16'(m_run);
    e.err        = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic wr(input bit sel, input logic [31:0] w);
    step(1, w, sel, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_op_a_or"}, 64'(|op_a), 64'd0);
    chk({nm, "_op_b_or"}, 64'(|op_b), 64'd0);
    chk({nm, "_cnts"}, {52'd0, a_cnt, b_cnt}, 64'd0);
    chk({nm, "_flags"}, {59'd0, in_ready, start, busy, res_valid, err}, 64'd0);
    chk({nm, "_run_cycles"}, 64'(run_cycles), 64'd0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle the DUT presents a new output snapshot, which is checked against the queue head
  always @(posedge clk) begin
    #1;
    if (resetn === 1'b1 && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk_op("op_a", op_a, mon_e.op_a);
      chk_op("op_b", op_b, mon_e.op_b);
      chk("a_cnt", 64'(a_cnt), 64'(mon_e.a_cnt));
      chk("b_cnt", 64'(b_cnt), 64'(mon_e.b_cnt));
      chk("in_ready", 64'(in_ready), 64'(mon_e.in_ready));
      chk("start", 64'(start), 64'(mon_e.start));
      chk("busy", 64'(busy), 64'(mon_e.busy));
      chk("res_valid", 64'(res_valid), 64'(mon_e.res_valid));
      chk("run_cycles", 64'(run_cycles), 64'(mon_e.run_cycles));
      chk("err", 64'(err), 64'(mon_e.err));
    end
  end

  initial begin
    resetn = 1'b0; in_valid = 0; in_word = '0; in_sel = 0; clr = 0; go = 0; mul_done = 0;
    model_reset();
    #20;
    chk_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Basic multiply: 40 RUN cycles
    step(0, 0, 0, 1, 0, 0);
    wr(0, 32'h1234_5678);
    wr(1, 32'h0000_0003);
    step(0, 0, 0, 0, 1, 0);
    idle(1);
    idle(39);
    step(0, 0, 0, 0, 0, 1);
    after_edge();
    chk("t1_run_cycles", 64'(run_cycles), 64'd40);
    chk("t1_res_valid", 64'(res_valid), 64'd1);
    chk("t1_op_a_lo", 64'(op_a[31:0]), 64'h1234_5678);

    // Overfill A with 33 words
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 33; i++) wr(0, 32'hA000_0000 + 32'(i));
    after_edge();
    chk("t2_a_cnt", 64'(a_cnt), 64'd32);
    chk("t2_top_word", 64'(op_a[1023:992]), 64'hA000_001F);
    chk("t2_err", 64'(err), 64'd1);

    // go with B empty, then a B word together with go
    step(0, 0, 0, 1, 0, 0);
    wr(0, 32'h0000_0011);
    step(0, 0, 0, 0, 1, 0);
    after_edge();
    chk("t3_go_rej_err", 64'(err), 64'd1);
    chk("t3_stay_load", 64'({in_ready, start}), 64'b10);
    wr(1, 32'h0000_0022);
    step(1, 32'h0000_0033, 1, 0, 1, 0);
    after_edge();
    chk("t3_start", 64'(start), 64'd1);
    chk("t3_op_b_w1", 64'(op_b[63:32]), 64'h33);

    // clr during RUN, then a stray mul_done
    idle(3);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    after_edge();
    chk("t4_cnts", {52'd0, a_cnt, b_cnt}, 64'd0);
    chk("t4_flags", {61'd0, in_ready, busy, res_valid}, 64'b100);

    // Write in DONE drops res_valid, go restarts
    wr(0, 32'h5);
    wr(1, 32'h7);
    step(0, 0, 0, 0, 1, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 1);
    wr(0, 32'h9);
    after_edge();
    chk("t5_res_valid", 64'(res_valid), 64'd0);
    chk("t5_a_cnt", 64'(a_cnt), 64'd2);
    step(0, 0, 0, 0, 1, 0);
    after_edge();
    chk("t5_restart", 64'(start), 64'd1);

    // Asynchronous reset mid-RUN, off the clock edge
    idle(5);
    @(posedge clk);
    #3;
    chk("t6_queue_drained", 64'(exp_q.size()), 64'd0);
    resetn = 1'b0;
    #1;
    chk_all_zero("t6_async");
    model_reset();
    in_valid = 0; clr = 0; go = 0; mul_done = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle(1);
    after_edge();
    chk("t6_load_after", 64'({in_ready, busy}), 64'b10);

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom % 10) < 5, $urandom, $urandom % 2, ($urandom % 100) < 2,
           ($urandom % 10) == 0, ($urandom % 8) == 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #5;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
